// File: rtl/prbs_pkg.sv
// -----------------------------------------------------------------------------
// prbs_pkg
//   Shared types and helpers for the serial PRBS checker.
//   - prbs_state_e : checker synchronisation state (HUNT / VERIFY / LOCKED)
//   - PRBS_MAX_W   : widest LFSR the parity helper accepts
//   - parity()     : XOR-reduction of a tapped LFSR window. Callers zero-extend
//                    their WIDTH-bit vector to PRBS_MAX_W. Zero bits do not
//                    change XOR parity, so one function serves every WIDTH up
//                    to PRBS_MAX_W.
// -----------------------------------------------------------------------------
package prbs_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  localparam int PRBS_MAX_W = 64;

  function automatic logic parity(input logic [PRBS_MAX_W-1:0] v);
    parity = ^v;
  endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// -----------------------------------------------------------------------------
// prbs_sat_counter
//   Registered up-counter that saturates at all-ones.
//   A clear that coincides with an increment loads 1, so the event that
//   happens during the clear cycle is still counted.
// Ports
//   clk  in  1      clock
//   rst  in  1      asynchronous active-high reset (q -> 0)
//   inc  in  1      count one event
//   clr  in  1      synchronous clear
//   q    out WIDTH  count value
// -----------------------------------------------------------------------------
module prbs_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1'b1);

  // Saturating count register with clear-plus-increment loading 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= inc ? ONE : '0;
    end else if (inc && (q != '1)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
//   Serial PRBS checker. It self-synchronises a local Fibonacci LFSR window to
//   the received bit stream, declares lock, and counts bit errors. It sits
//   downstream of the matching LFSR generator in link/loopback BIST.
//
//   Window convention: w[i] = s[n+i]. The expected next bit is ^(w & taps).
//   Each accepted bit shifts w right and enters at w[WIDTH-1].
//
// Optional build macro
//   PRBS_CHK_BITCNT_EN : adds the bit_cnt port, a saturating count of bits
//                        checked while LOCKED (for BER estimation).
//
// Ports
//   clk       in   1          clock
//   rst       in   1          asynchronous active-high reset
//   en        in   1          din valid; all state frozen when low
//   taps      in   WIDTH      feedback polynomial (generator encoding)
//   din       in   1          received serial bit
//   clr_errs  in   1          synchronous clear of err_cnt (and bit_cnt)
//   locked    out  1          checker is LOCKED
//   err       out  1          one-cycle pulse per mismatch while LOCKED
//   err_cnt   out  ERR_CNT_W  saturating error count
//   bit_cnt   out  ERR_CNT_W  saturating checked-bit count (macro only)
// -----------------------------------------------------------------------------
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int LOCK_COUNT  = 32,
  parameter int UNLOCK_ERRS = 8,
  parameter int ERR_CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     taps,
  input  logic                 din,
  input  logic                 clr_errs,
  output logic                 locked,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [ERR_CNT_W-1:0] bit_cnt
`endif
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);

  // Terminal values are compared before the increment, so a counter
  // "reaches" its limit on the same edge that accepts the final bit.
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_ERRS - 1);

  prbs_state_e       state_r;
  logic [WIDTH-1:0]  w_r;
  logic [FILL_W-1:0] fill_r;
  logic [RUN_W-1:0]  run_r;
  logic [BAD_W-1:0]  bad_r;
  logic              locked_r;
  logic              err_r;

  logic              exp_s;
  logic              mism_s;
  logic              err_ev_s;
  logic              clr_s;
  logic [WIDTH-1:0]  w_din_s;
  logic [WIDTH-1:0]  w_exp_s;

  // Predicted bit, mismatch flag and both candidate next windows
  always_comb begin
    exp_s    = parity(PRBS_MAX_W'(w_r & taps));
    mism_s   = din ^ exp_s;
    w_din_s  = {din,   w_r[WIDTH-1:1]};
    w_exp_s  = {exp_s, w_r[WIDTH-1:1]};
    err_ev_s = 1'b0;
    clr_s    = 1'b0;
    if (en) begin
      err_ev_s = (state_r == LOCKED) && mism_s;
      clr_s    = clr_errs;
    end else begin
      err_ev_s = 1'b0;
      clr_s    = 1'b0;
    end
  end

  // Synchronisation FSM with registered locked/err outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= HUNT;
      w_r      <= '0;
      fill_r   <= '0;
      run_r    <= '0;
      bad_r    <= '0;
      locked_r <= 1'b0;
      err_r    <= 1'b0;
    end else if (!en) begin
      err_r <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        HUNT: begin
          w_r <= w_din_s;
          if (fill_r == FILL_LAST) begin
            fill_r <= '0;
            // An all-zero window is the LFSR lock-up state; keep filling.
            if (w_din_s != '0) begin
              state_r <= VERIFY;
              run_r   <= '0;
            end
          end else begin
            fill_r <= fill_r + FILL_W'(1'b1);
          end
        end
        VERIFY: begin
          w_r <= w_din_s;
          if (mism_s) begin
            state_r <= HUNT;
            fill_r  <= '0;
            run_r   <= '0;
          end else if (run_r == RUN_LAST) begin
            state_r  <= LOCKED;
            locked_r <= 1'b1;
            run_r    <= '0;
            bad_r    <= '0;
          end else begin
            run_r <= run_r + RUN_W'(1'b1);
          end
        end
        LOCKED: begin
          // Feed the prediction back, not din, so one channel error
          // cannot corrupt the window and cause further errors.
          w_r <= w_exp_s;
          if (mism_s) begin
            err_r <= 1'b1;
            run_r <= '0;
            if (bad_r == BAD_LAST) begin
              state_r  <= HUNT;
              locked_r <= 1'b0;
              fill_r   <= '0;
              bad_r    <= '0;
            end else begin
              bad_r <= bad_r + BAD_W'(1'b1);
            end
          end else if (run_r == RUN_LAST) begin
            run_r <= '0;
            bad_r <= '0;
          end else begin
            run_r <= run_r + RUN_W'(1'b1);
          end
        end
        default: begin
          state_r  <= HUNT;
          fill_r   <= '0;
          run_r    <= '0;
          bad_r    <= '0;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  assign locked = locked_r;
  assign err    = err_r;

  prbs_sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_ev_s),
    .clr (clr_s),
    .q   (err_cnt)
  );

`ifdef PRBS_CHK_BITCNT_EN
  logic bit_ev_s;

  // Every accepted bit in LOCKED is a checked bit, including error bits
  always_comb begin
    bit_ev_s = 1'b0;
    if (en && (state_r == LOCKED)) begin
      bit_ev_s = 1'b1;
    end else begin
      bit_ev_s = 1'b0;
    end
  end

  prbs_sat_counter #(
    .WIDTH (ERR_CNT_W)
  ) u_bit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (bit_ev_s),
    .clr (clr_s),
    .q   (bit_cnt)
  );
`endif

endmodule

// File: tb/tb_prbs_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_prbs_checker
//   Directed bench for prbs_checker with WIDTH=7, taps x^7+x^6+1, a generator
//   seeded with 1, and a 4-bit error counter. Expected err/locked/err_cnt for
//   every clock are pushed to a scoreboard queue when the bit is driven. They
//   are popped and compared after the edge that consumes the bit.
// -----------------------------------------------------------------------------
module tb_prbs_checker;

  localparam int          W    = 7;
  localparam int          LC   = 32;
  localparam int          UE   = 8;
  localparam int          CW   = 4;
  localparam logic [W-1:0] TAPS = 7'h41;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [W-1:0]  taps;
  logic          din;
  logic          clr_errs;
  logic          locked;
  logic          err;
  logic [CW-1:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
  logic [CW-1:0] bit_cnt;
`endif

  prbs_checker #(
    .WIDTH       (W),
    .LOCK_COUNT  (LC),
    .UNLOCK_ERRS (UE),
    .ERR_CNT_W   (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .taps     (taps),
    .din      (din),
    .clr_errs (clr_errs),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt)
`ifdef PRBS_CHK_BITCNT_EN
    ,
    .bit_cnt  (bit_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic          locked;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Upstream generator state and expected checker behaviour
  logic [W-1:0]  gen_sr;
  logic          m_lk;
  int            m_acc;
  int            m_run;
  int            m_bad;
  logic [CW-1:0] m_cnt;

  function automatic logic gen_fb(input logic [W-1:0] s);
    return ^(s & TAPS);
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_out();
    exp_t x;
    x = sb_q.pop_front();
    cmp("err",     {31'd0, err},    {31'd0, x.err});
    cmp("locked",  {31'd0, locked}, {31'd0, x.locked});
    cmp("err_cnt", 32'(err_cnt),    32'(x.cnt));
  endtask

  task automatic model_reset();
    m_lk  = 1'b0;
    m_acc = 0;
    m_run = 0;
    m_bad = 0;
    m_cnt = '0;
  endtask

  // One clock: drive a generator bit (optionally inverted), record expectation
  task automatic step(input logic e, input logic inj, input logic clr);
    exp_t x;
    logic bitv;
    logic ev;
    ev   = 1'b0;
    bitv = gen_sr[0] ^ inj;
    if (e) begin
      gen_sr = {gen_fb(gen_sr), gen_sr[W-1:1]};
      if (!m_lk) begin
        m_acc++;
        if (m_acc == W + LC) begin
          m_lk  = 1'b1;
          m_run = 0;
          m_bad = 0;
        end
      end else if (inj) begin
        ev    = 1'b1;
        m_run = 0;
        m_bad++;
        if (m_bad == UE) begin
          m_lk  = 1'b0;
          m_acc = 0;
          m_bad = 0;
        end
      end else begin
        m_run++;
        if (m_run == LC) begin
          m_run = 0;
          m_bad = 0;
        end
      end
      if (clr) m_cnt = ev ? 4'd1 : 4'd0;
      else if (ev && (m_cnt != 4'hF)) m_cnt = m_cnt + 4'd1;
    end else begin
      bitv = 1'($urandom_range(0, 1));
    end
    en       = e;
    din      = bitv;
    clr_errs = clr;
    x = '{err: ev, locked: m_lk, cnt: m_cnt};
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // One clock of constant-zero input: never a valid LFSR state, never locks
  task automatic zero_step();
    exp_t x;
    en       = 1'b1;
    din      = 1'b0;
    clr_errs = 1'b0;
    x = '{err: 1'b0, locked: 1'b0, cnt: 4'd0};
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic do_reset(input logic reseed);
    en       = 1'b0;
    din      = 1'b0;
    clr_errs = 1'b0;
    rst      = 1'b1;
    if (reseed) gen_sr = 7'h01;
    model_reset();
    sb_q.delete();
    #1;
    cmp("rst_locked",  {31'd0, locked}, 32'd0);
    cmp("rst_err",     {31'd0, err},    32'd0);
    cmp("rst_err_cnt", 32'(err_cnt),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    taps = TAPS;

    // 1: clean stream locks after the 39th bit, no errors over 2000 bits
    do_reset(1'b1);
    for (int i = 0; i < W + LC - 1; i++) step(1'b1, 1'b0, 1'b0);
    cmp("t1_before_lock", {31'd0, locked}, 32'd0);
    step(1'b1, 1'b0, 1'b0);
    cmp("t1_lock_at_39", {31'd0, locked}, 32'd1);
    for (int i = W + LC; i < 2000; i++) step(1'b1, 1'b0, 1'b0);
    cmp("t1_err_cnt", 32'(err_cnt), 32'd0);

    // 2: single flipped bit 300 -> one err pulse, lock held
    do_reset(1'b1);
    for (int i = 1; i <= 500; i++) step(1'b1, (i == 300), 1'b0);
    cmp("t2_err_cnt", 32'(err_cnt), 32'd1);
    cmp("t2_locked",  {31'd0, locked}, 32'd1);

    // 3: 8 errors within 16 bits -> unlock, then relock in 39 bits
    do_reset(1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) step(1'b1, (k % 2 == 0), 1'b0);
    cmp("t3_unlocked", {31'd0, locked}, 32'd0);
    cmp("t3_err_cnt",  32'(err_cnt), 32'd8);
    for (int i = 0; i < W + LC - 2; i++) step(1'b1, 1'b0, 1'b0);
    cmp("t3_not_yet", {31'd0, locked}, 32'd0);
    step(1'b1, 1'b0, 1'b0);
    cmp("t3_relock", {31'd0, locked}, 32'd1);

    // 4: all-zero input never locks and never errors
    do_reset(1'b1);
    for (int i = 0; i < 500; i++) zero_step();
    cmp("t4_err_cnt", 32'(err_cnt), 32'd0);

    // 5: 20 errors spaced 40 bits saturate the 4-bit counter; clear cases
    do_reset(1'b1);
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 39; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
    cmp("t5_saturated", 32'(err_cnt), 32'd15);
    cmp("t5_locked",    {31'd0, locked}, 32'd1);
    for (int i = 0; i < 39; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    cmp("t5_clr_with_err", 32'(err_cnt), 32'd1);
    step(1'b1, 1'b0, 1'b1);
    cmp("t5_clr_alone", 32'(err_cnt), 32'd0);
    cmp("t5_lock_kept", {31'd0, locked}, 32'd1);

    // 6: 30% en duty locks at the same accepted-bit count, then rst mid-VERIFY
    do_reset(1'b1);
    for (int i = 0; i < 400; i++) step(($urandom_range(0, 99) < 30), 1'b0, 1'b0);
    cmp("t6_locked_sparse", {31'd0, locked}, 32'd1);
    cmp("t6_err_cnt",       32'(err_cnt), 32'd0);
    for (int k = 0; k < 16; k++) step(1'b1, (k % 2 == 0), 1'b0);
    cmp("t6_err_cnt_8", 32'(err_cnt), 32'd8);
    for (int i = 0; i < W + 5; i++) step(1'b1, 1'b0, 1'b0);
    #2;
    do_reset(1'b0);
    for (int i = 0; i < W + LC; i++) step(1'b1, 1'b0, 1'b0);
    cmp("t6_relock", {31'd0, locked}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
